// File: rtl/bus_seq_ctrl.sv
// Control-step sequencer for a single shared 32-bit datapath bus: walks fetch/execute steps and
// drives one bus source plus the matching load enables for ALU, ADDI, LD, ST, HALT and NOP.
module bus_seq_ctrl #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic [20:0] src_sel,
  output logic [15:0] reg_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        inc_pc,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  alu_op,
  output logic        halted,
  output logic        error,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_EX1, S_EX2, S_WB,
    S_MA, S_MR, S_LWB, S_SD, S_MW, S_HALT, S_ERR
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);
  localparam logic [4:0] SRC_PC    = 5'd0;
  localparam logic [4:0] SRC_MDR   = 5'd2;
  localparam logic [4:0] SRC_REG0  = 5'd3;
  localparam logic [4:0] SRC_CSIGN = 5'd19;
  localparam logic [4:0] SRC_Z     = 5'd20;

  state_t     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       op_alu, op_ld, op_st, op_halt, op_nop;
  logic       in_wait, timeout;
  logic       unused_ir;

  assign op        = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];

  assign op_alu  = (op < 5'd4);
  assign op_ld   = (op == 5'd5);
  assign op_st   = (op == 5'd6);
  assign op_halt = (op == 5'd7);
  assign op_nop  = (op >= 5'd8);

  // Memory handshake: mem_read/mem_write stay high for the whole wait state and the access
  // completes in the cycle mem_rdy is sampled high; mem_rdy in any other state is ignored.
  assign in_wait = (state_q == S_T1) || (state_q == S_MR) || (state_q == S_MW);
  assign timeout = in_wait && !mem_rdy && (wcnt_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (run) state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1: begin
        if (mem_rdy)      state_d = S_T2;
        else if (timeout) state_d = S_ERR;
      end
      S_T2:    state_d = S_EX1;
      S_EX1: begin
        if (op_halt)     state_d = S_HALT;
        else if (op_nop) state_d = run ? S_T0 : S_IDLE;
        else             state_d = S_EX2;
      end
      S_EX2:   state_d = (op_ld || op_st) ? S_MA : S_WB;
      S_WB:    state_d = run ? S_T0 : S_IDLE;
      S_MA:    state_d = op_ld ? S_MR : S_SD;
      S_MR: begin
        if (mem_rdy)      state_d = S_LWB;
        else if (timeout) state_d = S_ERR;
      end
      S_LWB:   state_d = run ? S_T0 : S_IDLE;
      S_SD:    state_d = S_MW;
      S_MW: begin
        if (mem_rdy)      state_d = run ? S_T0 : S_IDLE;
        else if (timeout) state_d = S_ERR;
      end
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Every wait state is entered from a different state, so a state change clears the count.
  always_comb begin
    wcnt_d = wcnt_q;
    if (state_d != state_q)       wcnt_d = 8'd0;
    else if (in_wait && !mem_rdy) wcnt_d = wcnt_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  logic       src_en, reg_en;
  logic [4:0] src_idx;
  logic [3:0] reg_idx;

  always_comb begin
    src_en    = 1'b0;
    src_idx   = 5'd0;
    reg_en    = 1'b0;
    reg_idx   = 4'd0;
    ir_in     = 1'b0;
    mar_in    = 1'b0;
    mdr_in    = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    inc_pc    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    alu_op    = 4'd0;
    halted    = 1'b0;
    error     = 1'b0;
    case (state_q)
      S_T0: begin
        src_en  = 1'b1;
        src_idx = SRC_PC;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
      end
      S_T1, S_MR: begin
        mem_read = 1'b1;
        mdr_in   = mem_rdy;
      end
      S_T2: begin
        src_en  = 1'b1;
        src_idx = SRC_MDR;
        ir_in   = 1'b1;
      end
      S_EX1: begin
        if (!op_halt && !op_nop) begin
          src_en  = 1'b1;
          src_idx = SRC_REG0 + 5'(rb);
          y_in    = 1'b1;
        end
      end
      S_EX2: begin
        src_en  = 1'b1;
        src_idx = op_alu ? (SRC_REG0 + 5'(rc)) : SRC_CSIGN;
        z_in    = 1'b1;
        alu_op  = op_alu ? op[3:0] : 4'd0;
      end
      S_WB: begin
        src_en  = 1'b1;
        src_idx = SRC_Z;
        reg_en  = 1'b1;
        reg_idx = ra;
      end
      S_MA: begin
        src_en  = 1'b1;
        src_idx = SRC_Z;
        mar_in  = 1'b1;
      end
      S_LWB: begin
        src_en  = 1'b1;
        src_idx = SRC_MDR;
        reg_en  = 1'b1;
        reg_idx = ra;
      end
      S_SD: begin
        src_en  = 1'b1;
        src_idx = SRC_REG0 + 5'(ra);
        mdr_in  = 1'b1;
      end
      S_MW:    mem_write = 1'b1;
      S_HALT:  halted    = 1'b1;
      S_ERR:   error     = 1'b1;
      default: ;
    endcase
  end

  assign src_sel   = src_en ? (21'd1 << src_idx) : 21'd0;
  assign reg_in    = reg_en ? (16'd1 << reg_idx) : 16'd0;
  assign pc_in     = 1'b0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_seq_ctrl.sv
// Bench for bus_seq_ctrl: a program of instructions is expanded into per-cycle stimulus and
// expected bus/enable vectors; a monitor compares the DUT outputs every cycle.
module tb_bus_seq_ctrl;

  localparam int WM = 15;

  localparam logic [8:0] EN_IR  = 9'b010000000;
  localparam logic [8:0] EN_MAR = 9'b001000000;
  localparam logic [8:0] EN_MDR = 9'b000100000;
  localparam logic [8:0] EN_Y   = 9'b000010000;
  localparam logic [8:0] EN_Z   = 9'b000001000;
  localparam logic [8:0] EN_INC = 9'b000000100;
  localparam logic [8:0] EN_RD  = 9'b000000010;
  localparam logic [8:0] EN_WR  = 9'b000000001;
  localparam logic [51:0] ZERO  = '0;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic [31:0] ir = '0;
  logic        mem_rdy = 1'b0;
  logic [20:0] src_sel;
  logic [15:0] reg_in;
  logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, inc_pc;
  logic        mem_read, mem_write, halted, error;
  logic [3:0]  alu_op;
  logic [3:0]  dbg_state;

  bus_seq_ctrl #(.WAIT_MAX(WM)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .ir(ir), .mem_rdy(mem_rdy),
    .src_sel(src_sel), .reg_in(reg_in), .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in),
    .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in), .inc_pc(inc_pc), .mem_read(mem_read),
    .mem_write(mem_write), .alu_op(alu_op), .halted(halted), .error(error),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        run;
    logic        rdy;
    logic        rst;
    logic [31:0] ir;
  } stim_t;

  stim_t       stim_q[$];
  logic [51:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        cyc_live = 1'b0;

  function automatic logic [51:0] mk(int src, int rg, logic [8:0] en, logic [3:0] alu,
                                     logic [1:0] he);
    logic [20:0] s;
    logic [15:0] r;
    s = '0;
    r = '0;
    if (src >= 0) s[src] = 1'b1;
    if (rg >= 0) r[rg] = 1'b1;
    return {s, r, en, alu, he};
  endfunction

  function automatic logic [31:0] mk_ir(int op, int ra, int rb, int rc, int c);
    return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'(c)};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(logic rn, logic rdy, logic rst, logic [31:0] irv, logic [51:0] e);
    stim_q.push_back({rn, rdy, rst, irv});
    exp_q.push_back(e);
  endtask

  // Reset pulsed inside the cycle; with run high the next cycle is T0.
  task automatic rst_cycle();
    push(1'b1, rbit(), 1'b1, $urandom, ZERO);
  endtask

  task automatic idle_tail(logic run_end);
    if (!run_end) begin
      int n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) push(1'b0, rbit(), 1'b0, $urandom, ZERO);
      push(1'b1, rbit(), 1'b0, $urandom, ZERO);
    end
  endtask

  task automatic mem_access(input logic wr, input int w, input logic rn,
                            input logic [31:0] irv, output bit to);
    logic [8:0] en;
    en = wr ? EN_WR : EN_RD;
    to = 1'b0;
    for (int i = 0; i < w && i < WM; i++) push(rn, 1'b0, 1'b0, irv, mk(-1, -1, en, 4'd0, 2'b00));
    if (w >= WM) begin
      to = 1'b1;
      for (int i = 0; i < 3; i++) push(rbit(), rbit(), 1'b0, irv, mk(-1, -1, 9'd0, 4'd0, 2'b01));
      rst_cycle();
    end else begin
      push(rn, 1'b1, 1'b0, irv, mk(-1, -1, wr ? EN_WR : (EN_RD | EN_MDR), 4'd0, 2'b00));
    end
  endtask

  task automatic instr(logic [31:0] irv, int wf, int wm, logic run_end, bit abort_ex2);
    int op, ra, rb, rc;
    bit to;
    op = int'(irv[31:27]);
    ra = int'(irv[26:23]);
    rb = int'(irv[22:19]);
    rc = int'(irv[18:15]);
    push(1'b1, rbit(), 1'b0, $urandom, mk(0, -1, EN_MAR | EN_INC, 4'd0, 2'b00));
    mem_access(1'b0, wf, 1'b1, $urandom, to);
    if (to) return;
    push(1'b1, rbit(), 1'b0, $urandom, mk(2, -1, EN_IR, 4'd0, 2'b00));
    if (op == 7) begin
      push(run_end, rbit(), 1'b0, irv, ZERO);
      for (int i = 0; i < 3; i++) push(rbit(), rbit(), 1'b0, irv, mk(-1, -1, 9'd0, 4'd0, 2'b10));
      rst_cycle();
      return;
    end
    if (op >= 8) begin
      push(run_end, rbit(), 1'b0, irv, ZERO);
      idle_tail(run_end);
      return;
    end
    push(run_end, rbit(), 1'b0, irv, mk(3 + rb, -1, EN_Y, 4'd0, 2'b00));
    if (abort_ex2) begin
      rst_cycle();
      return;
    end
    push(run_end, rbit(), 1'b0, irv,
         mk(op < 4 ? 3 + rc : 19, -1, EN_Z, op < 4 ? 4'(op) : 4'd0, 2'b00));
    if (op <= 4) begin
      push(run_end, rbit(), 1'b0, irv, mk(20, ra, 9'd0, 4'd0, 2'b00));
    end else begin
      push(run_end, rbit(), 1'b0, irv, mk(20, -1, EN_MAR, 4'd0, 2'b00));
      if (op == 5) begin
        mem_access(1'b0, wm, run_end, irv, to);
        if (to) return;
        push(run_end, rbit(), 1'b0, irv, mk(2, ra, 9'd0, 4'd0, 2'b00));
      end else begin
        push(run_end, rbit(), 1'b0, irv, mk(3 + ra, -1, EN_MDR, 4'd0, 2'b00));
        mem_access(1'b1, wm, run_end, irv, to);
        if (to) return;
      end
    end
    idle_tail(run_end);
  endtask

  task automatic build_program();
    rst_cycle();
    rst_cycle();
    instr(32'h0091_8000, 0, 0, 1'b1, 1'b0);
    instr(32'h2A28_0008, 0, 3, 1'b1, 1'b0);
    instr(32'h3338_0000, 0, 0, 1'b1, 1'b0);
    instr(32'h0091_8000, 0, 0, 1'b0, 1'b0);
    instr(mk_ir(4, 9, 10, 0, 5), WM - 1, 0, 1'b1, 1'b0);
    instr(mk_ir(5, 3, 11, 0, 1), 0, WM - 1, 1'b1, 1'b0);
    instr(mk_ir(6, 15, 0, 0, 2), 1, WM - 1, 1'b0, 1'b0);
    instr(mk_ir(2, 7, 8, 9, 0), 0, 0, 1'b1, 1'b1);
    instr(mk_ir(1, 1, 1, 1, 0), WM, 0, 1'b1, 1'b0);
    instr(mk_ir(5, 2, 3, 0, 4), 0, WM, 1'b1, 1'b0);
    instr(mk_ir(6, 4, 5, 0, 4), 0, WM, 1'b1, 1'b0);
    instr(mk_ir(20, 0, 0, 0, 0), 0, 0, 1'b0, 1'b0);
    instr(32'h3800_0000, 0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 60; k++) begin
      int op, wf, wm;
      op = $urandom_range(0, 9);
      if (op == 9) op = $urandom_range(8, 31);
      wf = ($urandom_range(0, 15) == 0) ? WM - 1 : $urandom_range(0, 3);
      wm = ($urandom_range(0, 15) == 0) ? WM - 1 : $urandom_range(0, 3);
      instr(mk_ir(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom), wf, wm, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
  endtask

  initial begin
    stim_t s;
    build_program();
    while (stim_q.size() > 0) begin
      @(posedge clock);
      #1;
      s = stim_q.pop_front();
      run = s.run;
      mem_rdy = s.rdy;
      ir = s.ir;
      cyc_live = 1'b1;
      if (s.rst) begin
        #1 reset_n = 1'b0;
        #6 reset_n = 1'b1;
      end
    end
    @(posedge clock);
    #1 cyc_live = 1'b0;
    repeat (2) @(posedge clock);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: got %0d unchecked expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  always @(negedge clock) begin
    if (cyc_live) begin
      logic [51:0] got, e;
      got = {src_sel, reg_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, inc_pc,
             mem_read, mem_write, alu_op, halted, error};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL outputs @%0t: got %h with no expectation queued", $time, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs @%0t (state %0d): got %h required %h", $time, dbg_state, got, e);
        end
      end
      vectors++;
      if ($countones(src_sel) > 1) begin
        miscompares++;
        $display("FAIL src_onehot @%0t: got %h required at most one bit", $time, src_sel);
      end
    end
  end

endmodule
